// File: rtl/y32_bit_alu.sv
// ---------------------------------------------------------------------------
// y32_bit_alu
//   Registered 32-bit integer ALU for the execute stage. It provides bitwise
//   AND and OR (with optional B inversion), add, subtract and set-on-less-than.
//   All outputs are registered, so the latency is one cycle. A new operation
//   is accepted on every clock.
//
//   Build option: ALU_OVERFLOW_EN
//     defined   : overflow is registered for the add/sub ops (op x10)
//     undefined : overflow logic is compiled out; overflow is tied to 0
//
// Ports
//   clk         in   1   rising-edge clock
//   rst_n       in   1   synchronous active-low reset
//   a, b        in  32   operands
//   cin         in   1   carry-in, used only when a2_select=0
//   less_select in   1   enables the SLT result for op x11
//   a2_select   in   1   op[2]: invert B and force carry-in to 1
//   a1_select   in   1   op[1]
//   a0_select   in   1   op[0]
//   result      out 32   registered result
//   cout        out  1   registered carry-out of bit 31 (arith/SLT ops only)
//   overflow    out  1   registered signed overflow (op x10 only)
// ---------------------------------------------------------------------------
module y32_bit_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    input  logic        less_select,
    input  logic        a2_select,
    input  logic        a1_select,
    input  logic        a0_select,
    output logic [31:0] result,
    output logic        cout,
    output logic        overflow
);

    logic [1:0]  op_lo;
    logic [31:0] bb;
    logic        ci;
    logic [32:0] sum;
    logic        ovf;
    logic        set_lt;

    logic [31:0] result_d, result_q;
    logic        cout_d,   cout_q;

    // The same B-inverted operand feeds both the logic ops and the adder.
    // That makes 100/101 give a&~b and a|~b, and 110 give a subtract.
    assign op_lo  = {a1_select, a0_select};
    assign bb     = a2_select ? ~b : b;
    assign ci     = a2_select ? 1'b1 : cin;
    assign sum    = {1'b0, a} + {1'b0, bb} + {32'd0, ci};
    assign ovf    = (a[31] == bb[31]) && (sum[31] != a[31]);
    // The sign of the difference, corrected when the subtraction overflows
    assign set_lt = sum[31] ^ ovf;

    always_comb begin
        result_d = 32'h0;
        cout_d   = 1'b0;
        case (op_lo)
            2'b00: result_d = a & bb;
            2'b01: result_d = a | bb;
            2'b10: begin
                result_d = sum[31:0];
                cout_d   = sum[32];
            end
            default: begin
                result_d = less_select ? {31'd0, set_lt} : 32'h0;
                cout_d   = sum[32];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= 32'h0;
            cout_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic overflow_d, overflow_q;

    // Overflow is reported for add/sub only. SLT consumes ovf internally
    // and does not expose it.
    assign overflow_d = (op_lo == 2'b10) ? ovf : 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_y32_bit_alu.sv
module tb_y32_bit_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic        cin, less_select, a2_select, a1_select, a0_select;
    logic [31:0] result;
    logic        cout, overflow;

    int checks = 0;
    int errors = 0;

`ifdef ALU_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    y32_bit_alu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .less_select (less_select),
        .a2_select   (a2_select),
        .a1_select   (a1_select),
        .a0_select   (a0_select),
        .result      (result),
        .cout        (cout),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1ns after rising edge.
    task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic vcin,
                         input logic vls, input logic [2:0] vop);
        @(negedge clk);
        a = va; b = vb; cin = vcin; less_select = vls;
        {a2_select, a1_select, a0_select} = vop;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 3'b010);
        rst_n = 1'b0;
        tick();
        checks++;
        if (result !== 32'h0 || cout !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: result=%h cout=%b ovf=%b, expected 0/0/0", result, cout, overflow);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        checks++;
        if (result !== 32'h8000_0000 || cout !== 1'b0 || overflow !== OVF_EN) begin
            errors++;
            $display("FAIL reset_release: result=%h cout=%b ovf=%b, expected 80000000/0/%b",
                     result, cout, overflow, OVF_EN);
        end
    endtask

    task automatic test_logic();
        logic [31:0] ta [4] = '{32'hC000_0000, 32'hC040_1000, 32'hFFFF_0000, 32'h0000_000F};
        logic [31:0] tb_ [4] = '{32'hC000_001F, 32'hC040_4003, 32'h0F0F_0F0F, 32'hFFFF_FF00};
        logic [2:0]  top [4] = '{3'b000, 3'b001, 3'b100, 3'b101};
        logic [31:0] texp[4] = '{32'hC000_0000, 32'hC040_5003, 32'hF0F0_0000, 32'h0000_00FF};
        for (int i = 0; i < 4; i++) begin
            drive(ta[i], tb_[i], 1'b1, 1'b1, top[i]);
            tick();
            checks++;
            if (result !== texp[i] || cout !== 1'b0 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL logic[%0d]: result=%h cout=%b ovf=%b, expected %h/0/0",
                         i, result, cout, overflow, texp[i]);
            end
        end
    endtask

    task automatic test_add();
        logic [31:0] ta [3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        logic [31:0] tb_ [3] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0002};
        logic        tci [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] texp[3] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0004};
        logic        tco [3] = '{1'b0, 1'b1, 1'b0};
        logic        tov [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(ta[i], tb_[i], tci[i], 1'b0, 3'b010);
            tick();
            checks++;
            if (result !== texp[i] || cout !== tco[i] || overflow !== (tov[i] & OVF_EN)) begin
                errors++;
                $display("FAIL add[%0d]: result=%h cout=%b ovf=%b, expected %h/%b/%b",
                         i, result, cout, overflow, texp[i], tco[i], tov[i] & OVF_EN);
            end
        end
    endtask

    task automatic test_sub();
        // cin=1 on the first vector: a2_select must ignore it
        logic [31:0] ta [3] = '{32'h0000_0005, 32'h0000_0007, 32'h8000_0000};
        logic [31:0] tb_ [3] = '{32'h0000_0007, 32'h0000_0005, 32'h0000_0001};
        logic        tci [3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] texp[3] = '{32'hFFFF_FFFE, 32'h0000_0002, 32'h7FFF_FFFF};
        logic        tco [3] = '{1'b0, 1'b1, 1'b1};
        logic        tov [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive(ta[i], tb_[i], tci[i], 1'b0, 3'b110);
            tick();
            checks++;
            if (result !== texp[i] || cout !== tco[i] || overflow !== (tov[i] & OVF_EN)) begin
                errors++;
                $display("FAIL sub[%0d]: result=%h cout=%b ovf=%b, expected %h/%b/%b",
                         i, result, cout, overflow, texp[i], tco[i], tov[i] & OVF_EN);
            end
        end
    endtask

    task automatic test_slt();
        logic [31:0] ta [6] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] tb_ [6] = '{32'h0000_0001, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001,
                                32'h0000_0001, 32'h0000_0000};
        logic        tls [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [2:0]  top [6] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b011, 3'b011};
        logic [31:0] texp[6] = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h1};
        logic        tco [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(ta[i], tb_[i], 1'b0, tls[i], top[i]);
            tick();
            checks++;
            if (result !== texp[i] || cout !== tco[i] || overflow !== 1'b0) begin
                errors++;
                $display("FAIL slt[%0d]: result=%h cout=%b ovf=%b, expected %h/%b/0",
                         i, result, cout, overflow, texp[i], tco[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        // A new op each cycle; each output reflects only the previous edge's inputs.
        drive(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 3'b010);
        tick();
        drive(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b1, 3'b111);
        checks++;
        if (result !== 32'h0000_0007 || cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_add: result=%h cout=%b, expected 00000007/0", result, cout);
        end
        tick();
        drive(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 3'b001);
        checks++;
        if (result !== 32'h0000_0001 || cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_slt: result=%h cout=%b, expected 00000001/0", result, cout);
        end
        tick();
        checks++;
        if (result !== 32'hFFFF_FFFF || cout !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_or: result=%h cout=%b ovf=%b, expected FFFFFFFF/0/0", result, cout, overflow);
        end
    endtask

    task automatic test_reset_midstream();
        drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 3'b010);
        tick();
        checks++;
        if (result !== 32'h0 || cout !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: result=%h cout=%b, expected 00000000/1", result, cout);
        end
        drive(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 3'b110);
        rst_n = 1'b0;
        tick();
        checks++;
        if (result !== 32'h0 || cout !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: result=%h cout=%b ovf=%b, expected 0/0/0", result, cout, overflow);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        checks++;
        if (result !== 32'h7FFF_FFFF || cout !== 1'b1 || overflow !== OVF_EN) begin
            errors++;
            $display("FAIL mid_release: result=%h cout=%b ovf=%b, expected 7FFFFFFF/1/%b",
                     result, cout, overflow, OVF_EN);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a = '0; b = '0; cin = 1'b0; less_select = 1'b0;
        a2_select = 1'b0; a1_select = 1'b0; a0_select = 1'b0;
        test_reset();
        test_logic();
        test_add();
        test_sub();
        test_slt();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
